// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, imem wait/timeout, load-use stall, halt.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WAIT_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_ready,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  output logic        pc_running,
  output logic        pc_write,
  output logic        keep_instr,
  output logic        flush_if_id,
  output logic        bubble_ex,
  output logic        fault,
  output logic [2:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start, everything quiet
  // RUN   | normal fetch; handles redirect, imem wait, load-use, system op
  // FLUSH | squashing IF/ID after a redirect
  // WAIT  | imem not ready; pipeline frozen, timeout counting
  // HALT  | stopped (system op or imem timeout) until rst
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The redirect cycle in RUN already flushes once, so the counter holds the remainder.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  // A redirect deferred from WAIT has not flushed yet, so it gets the full count.
  localparam logic [2:0] FLUSH_FULL   = 3'(FLUSH_CYCLES);
  localparam logic [7:0] WAIT_LAST    = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [2:0] flush_left_q, flush_left_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       redir_pend_q, redir_pend_d;
  logic       fault_q, fault_d;
  logic       uses_rs2;
  logic       load_use;

  assign uses_rs2 = (id_opcode == OP_REG) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BRANCH);
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_left_q <= 3'd0;
      wait_cnt_q   <= 8'd0;
      redir_pend_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      wait_cnt_q   <= wait_cnt_d;
      redir_pend_q <= redir_pend_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    wait_cnt_d   = wait_cnt_q;
    redir_pend_d = redir_pend_q;
    fault_d      = fault_q;
    pc_running   = 1'b0;
    pc_write     = 1'b0;
    keep_instr   = 1'b0;
    flush_if_id  = 1'b0;
    bubble_ex    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end

      ST_RUN: begin
        pc_running = 1'b1;
        pc_write   = 1'b1;
        if (ex_redirect) begin
          flush_if_id  = 1'b1;
          bubble_ex    = 1'b1;
          flush_left_d = FLUSH_RELOAD;
          state_d      = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else if (!imem_ready) begin
          keep_instr   = 1'b1;
          bubble_ex    = 1'b1;
          pc_write     = 1'b0;
          wait_cnt_d   = 8'd0;
          redir_pend_d = 1'b0;
          state_d      = ST_WAIT;
        end else if (load_use) begin
          keep_instr = 1'b1;
          bubble_ex  = 1'b1;
          pc_write   = 1'b0;
        end else if (id_opcode == OP_SYSTEM) begin
          state_d = ST_HALT;
        end
      end

      ST_FLUSH: begin
        pc_running  = 1'b1;
        flush_if_id = 1'b1;
        pc_write    = imem_ready;
        if (ex_redirect) begin
          flush_left_d = FLUSH_RELOAD;
          if (FLUSH_CYCLES == 1) state_d = ST_RUN;
        end else if (imem_ready) begin
          // This cycle's flush consumes the last count when the counter is at 1.
          if (flush_left_q <= 3'd1) begin
            flush_left_d = 3'd0;
            state_d      = ST_RUN;
          end else begin
            flush_left_d = flush_left_q - 3'd1;
          end
        end
      end

      ST_WAIT: begin
        pc_running = 1'b1;
        keep_instr = 1'b1;
        bubble_ex  = 1'b1;
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (ex_redirect) redir_pend_d = 1'b1;
        if (imem_ready) begin
          redir_pend_d = 1'b0;
          if (redir_pend_q || ex_redirect) begin
            flush_left_d = FLUSH_FULL;
            state_d      = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        keep_instr = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign fault   = fault_q;
  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (keep_instr && pc_running && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_if_id && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles IF/ID is flushed after an EX redirect (legal range 1..7).
REQ-002 SHALL have parameter WAIT_LIMIT, default 255: maximum consecutive imem-not-ready cycles before fault (legal range 1..255).
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-006 SHALL have port imem_ready, input, 1: instruction memory returns valid data this cycle.
REQ-007 SHALL have port id_opcode, input, 7: opcode of the instruction held in IF/ID.
REQ-008 SHALL have port id_rs1, input, 5: rs1 field of the IF/ID instruction.
REQ-009 SHALL have port id_rs2, input, 5: rs2 field of the IF/ID instruction.
REQ-010 SHALL have port ex_rd, input, 5: destination register of the instruction in EX.
REQ-011 SHALL have port ex_mem_read, input, 1: instruction in EX is a load.
REQ-012 SHALL have port ex_redirect, input, 1: taken branch or jump resolved in EX.
REQ-013 SHALL have port pc_running, output, 1: fetch enabled, drives IF/ID reset gating.
REQ-014 SHALL have port pc_write, output, 1: PC register update enable.
REQ-015 SHALL have port keep_instr, output, 1: hold IF/ID contents.
REQ-016 SHALL have port flush_if_id, output, 1: zero IF/ID contents at next edge.
REQ-017 SHALL have port bubble_ex, output, 1: insert NOP into ID/EX.
REQ-018 SHALL have port fault, output, 1: sticky imem timeout indicator.
REQ-019 SHALL have port state_o, output, 3: current state encoding (IDLE=0, RUN=1, FLUSH=2, WAIT=3, HALT=4).

Function
REQ-020 SHALL implement states IDLE, RUN, FLUSH, WAIT and HALT, with outputs decoded combinationally from state and inputs.
REQ-021 SHALL, in IDLE, drive all outputs 0 and move to RUN on the edge where start=1.
REQ-022 SHALL, in RUN, drive pc_running=1 and pc_write=1 unless overridden; events are prioritised redirect > imem wait > load-use > system opcode.
REQ-023 SHALL, in RUN with ex_redirect=1, assert flush_if_id=1 and bubble_ex=1 in the same cycle, load the flush counter with FLUSH_CYCLES-1, and go to FLUSH (or stay in RUN if FLUSH_CYCLES=1).
REQ-024 SHALL, in RUN with imem_ready=0, assert keep_instr=1, bubble_ex=1 and pc_write=0, clear the wait counter, and go to WAIT.
REQ-025 SHALL detect a load-use hazard as ex_mem_read=1 and ex_rd!=0 and (ex_rd==id_rs1, or ex_rd==id_rs2 with id_opcode in {0110011, 0100011, 1100011}).
REQ-026 SHALL, on a load-use hazard in RUN, assert keep_instr=1, bubble_ex=1 and pc_write=0 for exactly that cycle and remain in RUN.
REQ-027 SHALL, in RUN with id_opcode=1110011 and no higher-priority event, go to HALT; the system instruction itself still completes.
REQ-028 SHALL, in FLUSH, assert flush_if_id=1 and pc_write=imem_ready, decrement the counter only when imem_ready=1, and return to RUN once the counter reaches 0 and imem_ready=1.
REQ-029 SHALL, on ex_redirect=1 during FLUSH, reload the counter with FLUSH_CYCLES-1.
REQ-030 SHALL, in WAIT, hold keep_instr=1, bubble_ex=1 and pc_write=0, and increment an 8-bit wait counter each cycle.
REQ-031 SHALL, in WAIT with ex_redirect=1, latch a pending-redirect flag; on the cycle imem_ready=1 it goes to FLUSH if the flag is set, else to RUN.
REQ-032 SHALL, when the wait counter reaches WAIT_LIMIT while still in WAIT, set fault=1 and go to HALT.
REQ-033 SHALL, in HALT, drive pc_running=0, pc_write=0 and keep_instr=1, and leave HALT only on rst.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, enter IDLE and clear both counters, the pending-redirect flag, fault and the performance counters, regardless of the current state.
REQ-035 SHALL give rst priority over start and over all other inputs.

Configuration
REQ-036 SHALL, when HAZARD_PERF_CNT_EN is defined, add output stall_cnt[31:0], counting cycles with keep_instr=1 and pc_running=1.
REQ-037 SHALL, when HAZARD_PERF_CNT_EN is defined, add output flush_cnt[31:0], counting cycles with flush_if_id=1.
REQ-038 SHALL, when HAZARD_PERF_CNT_EN is defined, make both counters saturate at 0xFFFFFFFF.
REQ-039 SHALL, when HAZARD_PERF_CNT_EN is not defined, omit both ports and their logic entirely.

Verification
REQ-040 SHALL cover reset release: rst=1 then start=1 -> state_o goes 0 then 1 on the next edge, and pc_running=1.
REQ-041 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> keep_instr=1, bubble_ex=1 and pc_write=0 for one cycle; with ex_rd=0 -> no stall.
REQ-042 SHALL cover redirect: ex_redirect pulse with FLUSH_CYCLES=2 -> flush_if_id high for 2 cycles, then state_o=1.
REQ-043 SHALL cover the simultaneous case: ex_redirect=1 and imem_ready=0 in the same cycle -> FLUSH taken and the counter frozen until imem_ready=1.
REQ-044 SHALL cover timeout: imem_ready held 0 for 255 cycles -> fault=1, state_o=4, pc_running=0.
REQ-045 SHALL cover performance counters: with HAZARD_PERF_CNT_EN defined, 3 load-use stalls plus 1 redirect -> stall_cnt=3 and flush_cnt=2.
